// File: rtl/fpga_clk_emul_pkg.sv
// Shared definitions for the FPGA clock-emulation generator: register map,
// field positions and widths of the per-domain FLL-compatible config slave.
package fpga_clk_emul_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned LOCK_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_CFG1    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CFG2    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH = 2'd3;

  localparam int unsigned STATUS_LOCK_BIT = 0;
  localparam int unsigned STATUS_DIV_LSB  = 8;

  localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [LOCK_W-1:0] LOCK_ONE = {{(LOCK_W-1){1'b0}}, 1'b1};

  // A programmed value of zero behaves as one for both DIV and LOCK_CYC.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div == {DIV_W{1'b0}}) ? DIV_ONE : div;
  endfunction

  function automatic logic [LOCK_W-1:0] eff_lock(input logic [LOCK_W-1:0] cyc);
    return (cyc == {LOCK_W{1'b0}}) ? LOCK_ONE : cyc;
  endfunction

  function automatic logic [DATA_W-1:0] status_word(input logic lock,
                                                    input logic [DIV_W-1:0] div);
    logic [DATA_W-1:0] w;
    w = {DATA_W{1'b0}};
    w[STATUS_LOCK_BIT] = lock;
    w[STATUS_DIV_LSB +: DIV_W] = div;
    return w;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// One emulated FLL domain: req/ack config slave, registers, even divider
// running on the reference clock and a lock counter.
module clk_div_cfg
  import fpga_clk_emul_pkg::*;
#(
  parameter int unsigned DIV_RST      = 1,
  parameter int unsigned LOCK_CYC_RST = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              wrn_i,
  input  logic [ADDR_W-1:0] add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] r_data_o,
  output logic              lock_o,
  output logic              div_clk_o
);

  localparam logic [DIV_W-1:0]  DIV_RST_V  = DIV_RST[DIV_W-1:0];
  localparam logic [LOCK_W-1:0] LOCK_RST_V = LOCK_CYC_RST[LOCK_W-1:0];

  logic              armed_q, armed_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LOCK_W-1:0] lock_cyc_q, lock_cyc_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              clk_q, clk_d;
  logic              lock_q, lock_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic              accept_s;
  logic [DIV_W-1:0]  div_eff_s;
  logic [LOCK_W-1:0] lock_tgt_s;
  logic [LOCK_W:0]   lock_cnt_inc_s;

  // A request is taken only once per req assertion: armed_q re-arms when req is seen low.
  assign accept_s       = req_i & ~ack_q & armed_q;
  assign div_eff_s      = eff_div(div_q);
  assign lock_tgt_s     = eff_lock(lock_cyc_q);
  assign lock_cnt_inc_s = {1'b0, lock_cnt_q} + {{LOCK_W{1'b0}}, 1'b1};

  // Next-state: divider, lock counter, handshake and register access.
  always_comb begin
    armed_d    = armed_q;
    ack_d      = 1'b0;
    r_data_d   = {DATA_W{1'b0}};
    div_d      = div_q;
    lock_cyc_d = lock_cyc_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;

    if (cnt_q >= (div_eff_s - DIV_ONE)) begin
      cnt_d = {DIV_W{1'b0}};
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + DIV_ONE;
    end

    if (!lock_q) begin
      lock_cnt_d = lock_cnt_inc_s[LOCK_W-1:0];
      lock_d     = (lock_cnt_inc_s >= {1'b0, lock_tgt_s});
    end else begin
      lock_cnt_d = lock_cnt_q;
    end

    if (!req_i) begin
      armed_d = 1'b1;
    end else if (accept_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    if (accept_s) begin
      ack_d = 1'b1;
      if (wrn_i) begin
        case (add_i)
          ADDR_STATUS:  r_data_d = status_word(lock_q, div_eff_s);
          ADDR_CFG1:    r_data_d = {{(DATA_W-DIV_W){1'b0}}, div_q};
          ADDR_CFG2:    r_data_d = {{(DATA_W-LOCK_W){1'b0}}, lock_cyc_q};
          ADDR_SCRATCH: r_data_d = scratch_q;
          default:      r_data_d = {DATA_W{1'b0}};
        endcase
      end else begin
        // A CFG1 write restarts divider and lock, but the clock level is held.
        case (add_i)
          ADDR_CFG1: begin
            div_d      = data_i[DIV_W-1:0];
            cnt_d      = {DIV_W{1'b0}};
            clk_d      = clk_q;
            lock_cnt_d = {LOCK_W{1'b0}};
            lock_d     = 1'b0;
          end
          ADDR_CFG2:    lock_cyc_d = data_i[LOCK_W-1:0];
          ADDR_SCRATCH: scratch_d  = data_i;
          default:      scratch_d  = scratch_q;
        endcase
      end
    end else begin
      ack_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q    <= 1'b1;
      ack_q      <= 1'b0;
      r_data_q   <= {DATA_W{1'b0}};
      div_q      <= DIV_RST_V;
      lock_cyc_q <= LOCK_RST_V;
      scratch_q  <= {DATA_W{1'b0}};
      cnt_q      <= {DIV_W{1'b0}};
      clk_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_cnt_q <= {LOCK_W{1'b0}};
    end else begin
      armed_q    <= armed_d;
      ack_q      <= ack_d;
      r_data_q   <= r_data_d;
      div_q      <= div_d;
      lock_cyc_q <= lock_cyc_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign ack_o     = ack_q;
  assign r_data_o  = r_data_q;
  assign lock_o    = lock_q;
  assign div_clk_o = clk_q;

endmodule

// File: rtl/fpga_clk_emul_gen.sv
// FPGA stand-in for the soc/per/cluster FLLs: three independent divided
// clocks from ref_clk_i, each with its own config slave and lock flag.
module fpga_clk_emul_gen
  import fpga_clk_emul_pkg::*;
#(
  parameter int unsigned SOC_DIV_RST     = 1,
  parameter int unsigned PER_DIV_RST     = 2,
  parameter int unsigned CLUSTER_DIV_RST = 1,
  parameter int unsigned LOCK_CYC_RST    = 16
) (
  input  logic              ref_clk_i,
  input  logic              rstn_glob_i,
  input  logic              test_mode_i,
  input  logic              shift_enable_i,
  output logic              soc_clk_o,
  output logic              per_clk_o,
  output logic              cluster_clk_o,
  input  logic              soc_cfg_req_i,
  input  logic              soc_cfg_wrn_i,
  input  logic [ADDR_W-1:0] soc_cfg_add_i,
  input  logic [DATA_W-1:0] soc_cfg_data_i,
  output logic              soc_cfg_ack_o,
  output logic [DATA_W-1:0] soc_cfg_r_data_o,
  output logic              soc_cfg_lock_o,
  input  logic              per_cfg_req_i,
  input  logic              per_cfg_wrn_i,
  input  logic [ADDR_W-1:0] per_cfg_add_i,
  input  logic [DATA_W-1:0] per_cfg_data_i,
  output logic              per_cfg_ack_o,
  output logic [DATA_W-1:0] per_cfg_r_data_o,
  output logic              per_cfg_lock_o,
  input  logic              cluster_cfg_req_i,
  input  logic              cluster_cfg_wrn_i,
  input  logic [ADDR_W-1:0] cluster_cfg_add_i,
  input  logic [DATA_W-1:0] cluster_cfg_data_i,
  output logic              cluster_cfg_ack_o,
  output logic [DATA_W-1:0] cluster_cfg_r_data_o,
  output logic              cluster_cfg_lock_o
);

  logic soc_div_clk_s;
  logic per_div_clk_s;
  logic cluster_div_clk_s;
  logic unused_shift_enable_s;

  assign unused_shift_enable_s = shift_enable_i;

  clk_div_cfg #(.DIV_RST(SOC_DIV_RST), .LOCK_CYC_RST(LOCK_CYC_RST)) u_soc (
    .clk_i     (ref_clk_i),
    .rst_ni    (rstn_glob_i),
    .req_i     (soc_cfg_req_i),
    .wrn_i     (soc_cfg_wrn_i),
    .add_i     (soc_cfg_add_i),
    .data_i    (soc_cfg_data_i),
    .ack_o     (soc_cfg_ack_o),
    .r_data_o  (soc_cfg_r_data_o),
    .lock_o    (soc_cfg_lock_o),
    .div_clk_o (soc_div_clk_s)
  );

  clk_div_cfg #(.DIV_RST(PER_DIV_RST), .LOCK_CYC_RST(LOCK_CYC_RST)) u_per (
    .clk_i     (ref_clk_i),
    .rst_ni    (rstn_glob_i),
    .req_i     (per_cfg_req_i),
    .wrn_i     (per_cfg_wrn_i),
    .add_i     (per_cfg_add_i),
    .data_i    (per_cfg_data_i),
    .ack_o     (per_cfg_ack_o),
    .r_data_o  (per_cfg_r_data_o),
    .lock_o    (per_cfg_lock_o),
    .div_clk_o (per_div_clk_s)
  );

  clk_div_cfg #(.DIV_RST(CLUSTER_DIV_RST), .LOCK_CYC_RST(LOCK_CYC_RST)) u_cluster (
    .clk_i     (ref_clk_i),
    .rst_ni    (rstn_glob_i),
    .req_i     (cluster_cfg_req_i),
    .wrn_i     (cluster_cfg_wrn_i),
    .add_i     (cluster_cfg_add_i),
    .data_i    (cluster_cfg_data_i),
    .ack_o     (cluster_cfg_ack_o),
    .r_data_o  (cluster_cfg_r_data_o),
    .lock_o    (cluster_cfg_lock_o),
    .div_clk_o (cluster_div_clk_s)
  );

  // In test mode every domain runs directly on the reference clock.
  assign soc_clk_o     = test_mode_i ? ref_clk_i : soc_div_clk_s;
  assign per_clk_o     = test_mode_i ? ref_clk_i : per_div_clk_s;
  assign cluster_clk_o = test_mode_i ? ref_clk_i : cluster_div_clk_s;

endmodule

// File: tb/tb_fpga_clk_emul_gen.sv
// Self-checking bench for fpga_clk_emul_gen: directed table, corner sequences
// and randomized config traffic against a cycle-level behavioural model.
module tb_fpga_clk_emul_gen;

  logic ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  logic        rst_n, test_mode, shift_en;
  logic [2:0]  req, wrn, ack, lock, clko;
  logic [1:0]  add   [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];

  fpga_clk_emul_gen dut (
    .ref_clk_i(ref_clk), .rstn_glob_i(rst_n), .test_mode_i(test_mode), .shift_enable_i(shift_en),
    .soc_clk_o(clko[0]), .per_clk_o(clko[1]), .cluster_clk_o(clko[2]),
    .soc_cfg_req_i(req[0]), .soc_cfg_wrn_i(wrn[0]), .soc_cfg_add_i(add[0]),
    .soc_cfg_data_i(wdata[0]), .soc_cfg_ack_o(ack[0]), .soc_cfg_r_data_o(rdata[0]),
    .soc_cfg_lock_o(lock[0]),
    .per_cfg_req_i(req[1]), .per_cfg_wrn_i(wrn[1]), .per_cfg_add_i(add[1]),
    .per_cfg_data_i(wdata[1]), .per_cfg_ack_o(ack[1]), .per_cfg_r_data_o(rdata[1]),
    .per_cfg_lock_o(lock[1]),
    .cluster_cfg_req_i(req[2]), .cluster_cfg_wrn_i(wrn[2]), .cluster_cfg_add_i(add[2]),
    .cluster_cfg_data_i(wdata[2]), .cluster_cfg_ack_o(ack[2]), .cluster_cfg_r_data_o(rdata[2]),
    .cluster_cfg_lock_o(lock[2])
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Behavioural model: clock level = level at last restart, toggled once per DIV edges.
  logic [7:0]  m_div  [3];
  logic [15:0] m_lcyc [3];
  logic [31:0] m_scr  [3];
  int          m_edges[3];
  logic        m_lvl0 [3], m_lock[3], m_seen[3], m_ack[3], m_clk[3];
  logic [31:0] m_rd   [3];

  logic [31:0] rd_cap [3];
  int          ack_cyc[3];
  logic        lock_at_ack[3];

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_div[0] = 8'd1; m_div[1] = 8'd2; m_div[2] = 8'd1;
    for (int d = 0; d < 3; d++) begin
      m_lcyc[d] = 16'd16; m_scr[d] = 32'h0; m_edges[d] = 0;
      m_lvl0[d] = 1'b0; m_lock[d] = 1'b0; m_seen[d] = 1'b0;
      m_ack[d] = 1'b0; m_clk[d] = 1'b0; m_rd[d] = 32'h0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      logic       pre_lvl, pre_lock;
      logic [7:0] dv;
      int         tgt;
      pre_lvl  = m_clk[d];
      pre_lock = m_lock[d];
      dv       = (m_div[d] == 8'd0) ? 8'd1 : m_div[d];
      tgt      = eff(int'(m_lcyc[d]));
      m_edges[d]++;
      if (!m_lock[d] && m_edges[d] >= tgt) m_lock[d] = 1'b1;
      m_ack[d] = 1'b0;
      m_rd[d]  = 32'h0;
      if (req[d] && !m_seen[d]) begin
        m_seen[d] = 1'b1;
        m_ack[d]  = 1'b1;
        if (wrn[d]) begin
          case (add[d])
            2'd0:    m_rd[d] = {16'h0, dv, 7'h0, pre_lock};
            2'd1:    m_rd[d] = {24'h0, m_div[d]};
            2'd2:    m_rd[d] = {16'h0, m_lcyc[d]};
            default: m_rd[d] = m_scr[d];
          endcase
        end else begin
          case (add[d])
            2'd1: begin
              m_div[d] = wdata[d][7:0]; m_edges[d] = 0; m_lock[d] = 1'b0; m_lvl0[d] = pre_lvl;
            end
            2'd2:    m_lcyc[d] = wdata[d][15:0];
            2'd3:    m_scr[d]  = wdata[d];
            default: ;
          endcase
        end
      end else if (!req[d]) begin
        m_seen[d] = 1'b0;
      end
      m_clk[d] = m_lvl0[d] ^ (((m_edges[d] / eff(int'(m_div[d]))) % 2) == 1);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("clk[%0d]", d), {31'h0, clko[d]}, {31'h0, test_mode ? 1'b0 : m_clk[d]});
      chk($sformatf("lock[%0d]", d), {31'h0, lock[d]}, {31'h0, m_lock[d]});
      chk($sformatf("ack[%0d]", d), {31'h0, ack[d]}, {31'h0, m_ack[d]});
      chk($sformatf("rdata[%0d]", d), rdata[d], m_rd[d]);
    end
  endtask

  // One reference cycle: model steps on the rising edge, outputs checked after the falling edge.
  task automatic cycle();
    @(posedge ref_clk);
    if (rst_n) model_edge();
    if (test_mode) begin
      #1;
      chk("tm_clk_high", {29'h0, clko}, {29'h0, 3'b111});
    end
    @(negedge ref_clk);
    #1;
    cyc_n++;
    check_all();
  endtask

  task automatic run_req(input logic [2:0] m);
    logic [2:0] got;
    int         c0;
    got = 3'b000;
    c0  = cyc_n;
    for (int d = 0; d < 3; d++) if (m[d]) req[d] = 1'b1;
    for (int i = 0; i < 4 && ((got & m) != m); i++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        if (m[d] && ack[d] && !got[d]) begin
          got[d] = 1'b1; rd_cap[d] = rdata[d]; ack_cyc[d] = cyc_n; lock_at_ack[d] = lock[d];
        end
      end
    end
    req = req & ~m;
    cycle();
    for (int d = 0; d < 3; d++) begin
      if (m[d]) begin
        chk($sformatf("ack_seen[%0d]", d), {31'h0, got[d]}, 32'h1);
        if (got[d]) chk($sformatf("ack_latency[%0d]", d), ack_cyc[d] - c0, 32'd1);
      end
    end
  endtask

  task automatic xfer(input int d, input logic w, input logic [1:0] a, input logic [31:0] dat);
    logic [2:0] m;
    m = 3'b001 << d;
    wrn[d] = w; add[d] = a; wdata[d] = dat;
    run_req(m);
  endtask

  task automatic measure(input int d, output int per);
    int   last;
    logic prev;
    last = -1; per = -1; prev = clko[d];
    for (int i = 0; i < 600 && per < 0; i++) begin
      cycle();
      if (!prev && clko[d]) begin
        if (last >= 0) per = cyc_n - last;
        last = cyc_n;
      end
      prev = clko[d];
    end
  endtask

  typedef struct {
    int          dom;
    logic        wrn;
    logic [1:0]  add;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];
  int   rem [3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, rel;

    tbl[0]  = '{0, 1'b1, 2'd0, 32'h0,         32'h0000_0101};
    tbl[1]  = '{1, 1'b1, 2'd0, 32'h0,         32'h0000_0201};
    tbl[2]  = '{2, 1'b1, 2'd2, 32'h0,         32'h0000_0010};
    tbl[3]  = '{0, 1'b1, 2'd3, 32'h0,         32'h0000_0000};
    tbl[4]  = '{1, 1'b0, 2'd3, 32'hDEAD_BEEF, 32'h0};
    tbl[5]  = '{1, 1'b1, 2'd3, 32'h0,         32'hDEAD_BEEF};
    tbl[6]  = '{1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{1, 1'b1, 2'd0, 32'h0,         32'h0000_0201};
    tbl[8]  = '{2, 1'b0, 2'd2, 32'h1234_0005, 32'h0};
    tbl[9]  = '{2, 1'b1, 2'd2, 32'h0,         32'h0000_0005};
    tbl[10] = '{0, 1'b1, 2'd1, 32'h0,         32'h0000_0001};

    rst_n = 1'b0; test_mode = 1'b0; shift_en = 1'b0;
    req = 3'b000; wrn = 3'b000;
    for (int d = 0; d < 3; d++) begin add[d] = 2'd0; wdata[d] = 32'h0; rem[d] = 0; end
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    rel = cyc_n;

    // Default lock latency and divider periods.
    for (int i = 0; i < 40 && !lock[0]; i++) cycle();
    chk("reset_lock_latency", cyc_n - rel, 32'd16);
    measure(0, per); chk("soc_default_period", per, 32'd2);
    measure(1, per); chk("per_default_period", per, 32'd4);
    measure(2, per); chk("cluster_default_period", per, 32'd2);

    foreach (tbl[i]) begin
      xfer(tbl[i].dom, tbl[i].wrn, tbl[i].add, tbl[i].data);
      if (tbl[i].wrn) chk($sformatf("table_read_%0d", i), rd_cap[tbl[i].dom], tbl[i].exp);
    end

    // soc DIV=5: lock drops with the ack, relocks 16 cycles later, period 10.
    xfer(0, 1'b0, 2'd1, 32'd5);
    chk("soc_lock_drop", {31'h0, lock_at_ack[0]}, 32'h0);
    for (int i = 0; i < 40 && !lock[0]; i++) cycle();
    chk("soc_relock_latency", cyc_n - ack_cyc[0], 32'd16);
    measure(0, per); chk("soc_div5_period", per, 32'd10);
    xfer(0, 1'b1, 2'd1, 32'h0); chk("soc_cfg1_read", rd_cap[0], 32'h5);

    // per DIV=0 runs as DIV=1.
    xfer(1, 1'b0, 2'd1, 32'd0);
    measure(1, per); chk("per_div0_period", per, 32'd2);

    // Simultaneous reads in all three domains.
    wrn = 3'b111;
    add[0] = 2'd1; add[1] = 2'd3; add[2] = 2'd2;
    run_req(3'b111);
    chk("conc_ack_soc_per", ack_cyc[0], ack_cyc[1]);
    chk("conc_ack_soc_cluster", ack_cyc[0], ack_cyc[2]);
    chk("conc_soc_data", rd_cap[0], 32'h5);
    chk("conc_per_data", rd_cap[1], 32'hDEAD_BEEF);
    chk("conc_cluster_data", rd_cap[2], 32'h5);

    // Test-mode bypass while the slave keeps working.
    test_mode = 1'b1;
    xfer(2, 1'b0, 2'd3, 32'h0BAD_F00D);
    xfer(2, 1'b1, 2'd3, 32'h0);
    chk("tm_scratch_read", rd_cap[2], 32'h0BAD_F00D);
    test_mode = 1'b0;
    repeat (2) cycle();

    // Randomized traffic on all domains against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (req[d]) begin
          if (ack[d]) begin req[d] = 1'b0; rem[d] = $urandom_range(1, 4); end
        end else if (rem[d] == 0) begin
          wrn[d] = 1'($urandom_range(0, 1));
          add[d] = 2'($urandom_range(0, 3));
          case (add[d])
            2'd1:    wdata[d] = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 4);
            2'd2:    wdata[d] = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 30);
            default: wdata[d] = $urandom;
          endcase
          req[d] = 1'b1;
        end else begin
          rem[d]--;
        end
      end
      cycle();
    end
    req = 3'b000;
    cycle();

    // Reset in the middle of a request aborts it and restores defaults.
    xfer(0, 1'b0, 2'd3, 32'h5555_AAAA);
    xfer(1, 1'b0, 2'd1, 32'd7);
    wrn[0] = 1'b1; add[0] = 2'd3; req[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ack", {29'h0, ack}, 32'h0);
    chk("rst_clk", {29'h0, clko}, 32'h0);
    chk("rst_lock", {29'h0, lock}, 32'h0);
    repeat (3) cycle();
    req = 3'b000;
    rst_n = 1'b1;
    cycle();
    xfer(0, 1'b1, 2'd3, 32'h0); chk("rst_soc_scratch", rd_cap[0], 32'h0);
    xfer(1, 1'b1, 2'd1, 32'h0); chk("rst_per_cfg1", rd_cap[1], 32'h2);
    xfer(2, 1'b1, 2'd2, 32'h0); chk("rst_cluster_cfg2", rd_cap[2], 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
